// File: rtl/tmds_rx_decoder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tmds_rx_decoder
//
// Purpose:
//   Receive-side decoder for one TMDS channel. The deserializer hands us raw
//   10-bit words with unknown symbol boundaries. We slide a 10-bit window
//   across two consecutive words until control tokens appear steadily at one
//   bit offset, then decode every aligned symbol into pixel data or a control
//   value. Lock is dropped if control tokens disappear for too long.
//
// Ports:
//   clk_25mhz    in   1   pixel clock
//   reset        in   1   synchronous, active-high
//   i_sym        in  10   raw deserialized word, bit 0 = earliest serial bit
//   o_data       out  8   decoded pixel byte (0 while a token is decoded)
//   o_ctrl       out  2   last decoded control value {C1,C0}
//   o_de         out  1   o_data carries valid video
//   o_locked     out  1   symbol alignment achieved
//   o_offset     out  4   bit offset of the alignment window, 0..9
//   o_lock_lost  out  1   single-cycle pulse when lock is dropped
// ---------------------------------------------------------------------------
module tmds_rx_decoder #(
    parameter int LOCK_TOKENS    = 16,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int LOSS_TIMEOUT   = 2048
) (
    input  logic       clk_25mhz,
    input  logic       reset,
    input  logic [9:0] i_sym,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl,
    output logic       o_de,
    output logic       o_locked,
    output logic [3:0] o_offset,
    output logic       o_lock_lost
);

    localparam int RUN_W   = $clog2(LOCK_TOKENS) + 1;
    localparam int DWELL_W = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int GAP_W   = $clog2(LOSS_TIMEOUT) + 1;

    localparam logic [RUN_W-1:0]   RUN_LOCK   = RUN_W'(LOCK_TOKENS);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEARCH_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(LOSS_TIMEOUT - 1);

    typedef enum logic {
        ST_SEARCH,
        ST_LOCKED
    } state_t;

    // Returns {isToken, ctrl[1:0]} for a 10-bit aligned symbol.
    function automatic logic [2:0] tokenLookup(input logic [9:0] sym);
        case (sym)
            10'h354: return 3'b100;
            10'h0AB: return 3'b101;
            10'h154: return 3'b110;
            10'h2AB: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         offset_q, offset_d;
    logic [RUN_W-1:0]   runCnt_q, runCnt_d;
    logic [DWELL_W-1:0] dwellCnt_q, dwellCnt_d;
    logic [GAP_W-1:0]   gapCnt_q, gapCnt_d;
    logic               locked_q, locked_d;
    logic               lockLost_q, lockLost_d;

    logic [9:0]  prevSym_q;
    logic [9:0]  alignWord_q;
    logic [19:0] window;
    logic [9:0]  alignedNow;
    logic [2:0]  nowLookup;
    logic        nowIsToken;

    logic [2:0]  stageLookup;
    logic [7:0]  unmasked;
    logic [7:0]  decoded;
    logic [7:0]  data_q;
    logic [1:0]  ctrl_q;
    logic        de_q;

    // The earlier word sits in the low half, so shifting right by the offset
    // walks the window forward in serial-bit order.
    assign window     = {i_sym, prevSym_q};
    assign alignedNow = 10'(window >> offset_q);
    assign nowLookup  = tokenLookup(alignedNow);
    assign nowIsToken = nowLookup[2];

    // Stage 1: remember the previous raw word and capture the aligned symbol.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            prevSym_q   <= '0;
            alignWord_q <= '0;
        end else begin
            prevSym_q   <= i_sym;
            alignWord_q <= alignedNow;
        end
    end

    // Alignment FSM state and counters.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state_q    <= ST_SEARCH;
            offset_q   <= '0;
            runCnt_q   <= '0;
            dwellCnt_q <= '0;
            gapCnt_q   <= '0;
            locked_q   <= 1'b0;
            lockLost_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            runCnt_q   <= runCnt_d;
            dwellCnt_q <= dwellCnt_d;
            gapCnt_q   <= gapCnt_d;
            locked_q   <= locked_d;
            lockLost_q <= lockLost_d;
        end
    end

    // Next-state logic. In SEARCH a lock decision takes priority over the
    // dwell timeout, so a run completing on the last dwell cycle keeps the
    // current offset. All counters saturate instead of wrapping.
    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        runCnt_d   = runCnt_q;
        dwellCnt_d = dwellCnt_q;
        gapCnt_d   = gapCnt_q;
        locked_d   = locked_q;
        lockLost_d = 1'b0;

        case (state_q)
            ST_SEARCH: begin
                locked_d = 1'b0;
                gapCnt_d = '0;
                if (nowIsToken) begin
                    runCnt_d = (runCnt_q == '1) ? runCnt_q : runCnt_q + 1'b1;
                end else begin
                    runCnt_d = '0;
                end
                dwellCnt_d = (dwellCnt_q == '1) ? dwellCnt_q : dwellCnt_q + 1'b1;

                if (nowIsToken && (runCnt_d >= RUN_LOCK)) begin
                    state_d    = ST_LOCKED;
                    locked_d   = 1'b1;
                    runCnt_d   = '0;
                    dwellCnt_d = '0;
                end else if (dwellCnt_q >= DWELL_LAST) begin
                    offset_d   = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                    runCnt_d   = '0;
                    dwellCnt_d = '0;
                end
            end

            ST_LOCKED: begin
                locked_d   = 1'b1;
                runCnt_d   = '0;
                dwellCnt_d = '0;
                if (nowIsToken) begin
                    gapCnt_d = '0;
                end else if (gapCnt_q >= GAP_LAST) begin
                    state_d    = ST_SEARCH;
                    locked_d   = 1'b0;
                    lockLost_d = 1'b1;
                    gapCnt_d   = '0;
                end else begin
                    gapCnt_d = (gapCnt_q == '1) ? gapCnt_q : gapCnt_q + 1'b1;
                end
            end

            default: begin
                state_d  = ST_SEARCH;
                locked_d = 1'b0;
            end
        endcase
    end

    // TMDS data decode: undo the optional inversion (bit 9), then undo the
    // XOR/XNOR chain selected by bit 8.
    always_comb begin
        stageLookup = tokenLookup(alignWord_q);
        unmasked    = alignWord_q[9] ? ~alignWord_q[7:0] : alignWord_q[7:0];
        decoded     = '0;
        decoded[0]  = unmasked[0];
        for (int i = 1; i < 8; i++) begin
            decoded[i] = alignWord_q[8] ? (unmasked[i] ^ unmasked[i-1])
                                        : ~(unmasked[i] ^ unmasked[i-1]);
        end
    end

    // Stage 2: register the decoded symbol. o_ctrl only changes on tokens so
    // it keeps the most recent control value through active video.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            data_q <= '0;
            ctrl_q <= '0;
            de_q   <= 1'b0;
        end else if (stageLookup[2]) begin
            data_q <= '0;
            ctrl_q <= stageLookup[1:0];
            de_q   <= 1'b0;
        end else begin
            data_q <= decoded;
            de_q   <= locked_q;
        end
    end

    assign o_data      = data_q;
    assign o_ctrl      = ctrl_q;
    assign o_de        = de_q;
    assign o_locked    = locked_q;
    assign o_offset    = offset_q;
    assign o_lock_lost = lockLost_q;

endmodule

// File: tb/tb_tmds_rx_decoder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_tmds_rx_decoder
//
// Directed bench for tmds_rx_decoder. A serial symbol stream is rebuilt into
// deserializer words with a chosen bit rotation, so the decoder has to find
// the matching offset. A symbol sent by applyStimulus call k is visible on
// o_data/o_ctrl/o_de after call k+2 returns; its effect on the lock state is
// visible after call k+1 returns.
// ---------------------------------------------------------------------------
module tb_tmds_rx_decoder;

    localparam logic [9:0] TOK00 = 10'h354;
    localparam logic [9:0] TOK01 = 10'h0AB;
    localparam logic [9:0] TOK10 = 10'h154;
    localparam logic [9:0] TOK11 = 10'h2AB;

    logic       clk_25mhz = 1'b0;
    logic       reset     = 1'b1;
    logic [9:0] i_sym     = '0;
    logic [7:0] o_data;
    logic [1:0] o_ctrl;
    logic       o_de;
    logic       o_locked;
    logic [3:0] o_offset;
    logic       o_lock_lost;

    int         checks  = 0;
    int         errors  = 0;
    int         rot     = 0;
    int         pulses  = 0;
    logic [9:0] lastSym = TOK00;

    tmds_rx_decoder dut (
        .clk_25mhz  (clk_25mhz),
        .reset      (reset),
        .i_sym      (i_sym),
        .o_data     (o_data),
        .o_ctrl     (o_ctrl),
        .o_de       (o_de),
        .o_locked   (o_locked),
        .o_offset   (o_offset),
        .o_lock_lost(o_lock_lost)
    );

    // 25 MHz pixel clock.
    always #20 clk_25mhz = ~clk_25mhz;

    // Safety net so the run always ends even if something stalls.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_25mhz);
        #1;
    endtask

    // Sends one symbol of the serial stream, packed into a deserializer word
    // that is rotated by 'rot' bits relative to the symbol boundary.
    task automatic applyStimulus(input logic [9:0] sym);
        logic [19:0] tmp;
        tmp     = {sym, lastSym} >> (10 - rot);
        i_sym   = tmp[9:0];
        lastSym = sym;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic resetDut(input int newRot);
        reset   = 1'b1;
        i_sym   = '0;
        rot     = newRot;
        lastSym = TOK00;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state.
        reset = 1'b1;
        repeat (3) tick();
        checkOutput("rst_data",   16'(o_data),      16'h00);
        checkOutput("rst_ctrl",   16'(o_ctrl),      16'h0);
        checkOutput("rst_de",     16'(o_de),        16'h0);
        checkOutput("rst_locked", 16'(o_locked),    16'h0);
        checkOutput("rst_offset", 16'(o_offset),    16'h0);
        checkOutput("rst_lost",   16'(o_lock_lost), 16'h0);
        reset = 1'b0;

        // Aligned stream at offset 0: lock appears after the 16th token.
        repeat (16) applyStimulus(TOK00);
        checkOutput("lock_early", 16'(o_locked), 16'h0);
        applyStimulus(TOK00);
        checkOutput("lock_16",    16'(o_locked), 16'h1);
        checkOutput("lock_off0",  16'(o_offset), 16'h0);
        repeat (143) applyStimulus(TOK00);

        applyStimulus(10'h0FF);
        applyStimulus(10'h100);
        applyStimulus(TOK00);
        checkOutput("dat_0ff",    16'(o_data), 16'hFF);
        checkOutput("de_0ff",     16'(o_de),   16'h1);
        applyStimulus(TOK00);
        checkOutput("dat_100",    16'(o_data), 16'h00);
        checkOutput("de_100",     16'(o_de),   16'h1);
        applyStimulus(TOK00);
        checkOutput("de_tok",     16'(o_de),   16'h0);

        // Control tokens, with a data word proving o_ctrl holds its value.
        applyStimulus(TOK01);
        applyStimulus(TOK10);
        applyStimulus(TOK11);
        checkOutput("ctrl_01",    16'(o_ctrl), 16'h1);
        checkOutput("ctrl01_de",  16'(o_de),   16'h0);
        checkOutput("ctrl01_dat", 16'(o_data), 16'h00);
        applyStimulus(10'h0FF);
        checkOutput("ctrl_10",    16'(o_ctrl), 16'h2);
        checkOutput("ctrl10_de",  16'(o_de),   16'h0);
        applyStimulus(TOK00);
        checkOutput("ctrl_11",    16'(o_ctrl), 16'h3);
        checkOutput("ctrl11_de",  16'(o_de),   16'h0);
        applyStimulus(TOK00);
        checkOutput("hold_dat",   16'(o_data), 16'hFF);
        checkOutput("hold_ctrl",  16'(o_ctrl), 16'h3);
        checkOutput("hold_de",    16'(o_de),   16'h1);
        applyStimulus(TOK00);
        checkOutput("ctrl_00",    16'(o_ctrl), 16'h0);
        checkOutput("ctrl00_de",  16'(o_de),   16'h0);

        // Inverted / XNOR and plain / XOR decode paths.
        applyStimulus(10'h2AA);
        applyStimulus(10'h1F0);
        applyStimulus(TOK00);
        checkOutput("dat_2aa",    16'(o_data), 16'h01);
        applyStimulus(TOK00);
        checkOutput("dat_1f0",    16'(o_data), 16'h10);

        // Token run broken by one data word at run=15 must restart the count.
        resetDut(0);
        repeat (15) applyStimulus(TOK00);
        applyStimulus(10'h0FF);
        repeat (16) applyStimulus(TOK00);
        checkOutput("brk_nolock", 16'(o_locked), 16'h0);
        applyStimulus(TOK00);
        checkOutput("brk_lock",   16'(o_locked), 16'h1);

        // Stream rotated by 7 bits: offset steps every 2048 cycles.
        resetDut(7);
        repeat (2047) applyStimulus(TOK00);
        checkOutput("srch_off0",  16'(o_offset), 16'h0);
        applyStimulus(TOK00);
        checkOutput("srch_off1",  16'(o_offset), 16'h1);
        repeat (12303) applyStimulus(TOK00);
        checkOutput("rot7_off",   16'(o_offset), 16'h7);
        checkOutput("rot7_early", 16'(o_locked), 16'h0);
        applyStimulus(TOK00);
        checkOutput("rot7_lock",  16'(o_locked), 16'h1);
        checkOutput("rot7_off2",  16'(o_offset), 16'h7);
        applyStimulus(10'h0FF);
        applyStimulus(10'h100);
        applyStimulus(TOK00);
        checkOutput("rot7_d0ff",  16'(o_data), 16'hFF);
        checkOutput("rot7_de",    16'(o_de),   16'h1);
        applyStimulus(TOK00);
        checkOutput("rot7_d100",  16'(o_data), 16'h00);

        // Loss of lock after 2048 cycles without a token.
        pulses = 0;
        repeat (2048) begin
            applyStimulus(10'h0FF);
            if (o_lock_lost) pulses++;
        end
        checkOutput("loss_early", 16'(o_locked), 16'h1);
        applyStimulus(10'h0FF);
        if (o_lock_lost) pulses++;
        checkOutput("loss_pulse", 16'(o_lock_lost), 16'h1);
        checkOutput("loss_lock",  16'(o_locked),    16'h0);
        checkOutput("loss_off",   16'(o_offset),    16'h7);
        applyStimulus(10'h0FF);
        if (o_lock_lost) pulses++;
        checkOutput("loss_end",   16'(o_lock_lost), 16'h0);
        checkOutput("loss_count", 16'(pulses),      16'h1);

        // Reset while locked at offset 5.
        resetDut(5);
        repeat (10255) applyStimulus(TOK00);
        checkOutput("rot5_early", 16'(o_locked), 16'h0);
        applyStimulus(TOK00);
        checkOutput("rot5_lock",  16'(o_locked), 16'h1);
        checkOutput("rot5_off",   16'(o_offset), 16'h5);
        applyStimulus(10'h0FF);
        applyStimulus(TOK00);
        applyStimulus(TOK00);
        checkOutput("rot5_dat",   16'(o_data), 16'hFF);
        reset = 1'b1;
        tick();
        checkOutput("mid_locked", 16'(o_locked),    16'h0);
        checkOutput("mid_offset", 16'(o_offset),    16'h0);
        checkOutput("mid_de",     16'(o_de),        16'h0);
        checkOutput("mid_data",   16'(o_data),      16'h00);
        checkOutput("mid_ctrl",   16'(o_ctrl),      16'h0);
        checkOutput("mid_lost",   16'(o_lock_lost), 16'h0);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
